// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad write sequencer.
//   wr_state_t  : which operand is being entered (ENTER_A / ENTER_B)
//   key_t       : decoded key class after flag prioritisation
//   encode_key  : collapses the one-hot-ish key flags into a single key_t
//   at_least_one: clamps a derived width to a minimum of one bit
package keypad_pkg;

    typedef enum logic {
        ENTER_A,
        ENTER_B
    } wr_state_t;

    typedef enum logic [2:0] {
        K_NONE,
        K_DIG,
        K_REG,
        K_OP,
        K_CLR,
        K_BKSP
    } key_t;

    // Several flags may be set at once; clear always wins, digits lose to everything.
    function automatic key_t encode_key(
        input logic isclr,
        input logic isbksp,
        input logic isreg,
        input logic isop,
        input logic isdig
    );
        if (isclr)       return K_CLR;
        else if (isbksp) return K_BKSP;
        else if (isreg)  return K_REG;
        else if (isop)   return K_OP;
        else if (isdig)  return K_DIG;
        else             return K_NONE;
    endfunction

    function automatic int at_least_one(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/strobe_edge_det.sv
// Rising-edge detector for the keypad strobe.
//   clk, rst : system clock, synchronous active-high reset
//   strobe   : level strobe from the keypad decoder
//   rise     : high while strobe is high and was low on the previous edge
// RESET_VAL sets the remembered level after reset; 1 means a strobe already
// high when reset releases is not treated as a new key press.
module strobe_edge_det #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    output logic rise
);

    logic strobe_d;
    logic strobe_q;

    // NOTE: every signal assigned in an always_comb gets a value on every path
    // (here trivially); a missed path would infer a latch.
    always_comb begin
        strobe_d = strobe;
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_q <= RESET_VAL;
        end else begin
            strobe_q <= strobe_d;
        end
    end

    assign rise = strobe & ~strobe_q;

endmodule

// File: rtl/keypad_write_fsm.sv
// Keypad write sequencer: turns key events into one-cycle control pulses for
// the digit registers (store_dig/del_dig), register file (reg_num) and ALU
// result stage (result_ready), plus clear_all and key_err.
//   clk, rst        : system clock, synchronous active-high reset
//   key_strobe      : level strobe; a key event is its rising edge
//   isdig..isbksp   : key class flags, sampled on the event edge
//   store_dig       : pulse, latch digit dig_idx of operand operand_sel
//   del_dig         : pulse, invalidate digit dig_idx of operand operand_sel
//   dig_idx         : digit position accompanying store_dig / del_dig
//   operand_sel     : 0 = operand A, 1 = operand B
//   reg_num         : pulse, operand A complete and register key accepted
//   result_ready    : pulse, operand B complete and operator accepted
//   clear_all       : pulse, all operands discarded (clear key or timeout)
//   key_err         : pulse, key event rejected in the current state
//   digit_count     : digits held in the current operand (post-update value)
module keypad_write_fsm
    import keypad_pkg::*;
#(
    parameter  int MAX_DIGITS     = 2,
    parameter  int TIMEOUT_CYCLES = 0,
    localparam int DIG_W          = at_least_one($clog2(MAX_DIGITS)),
    localparam int CNT_W          = $clog2(MAX_DIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_strobe,
    input  logic             isdig,
    input  logic             isreg,
    input  logic             isop,
    input  logic             isclr,
    input  logic             isbksp,
    output logic             store_dig,
    output logic             del_dig,
    output logic [DIG_W-1:0] dig_idx,
    output logic             operand_sel,
    output logic             reg_num,
    output logic             result_ready,
    output logic             clear_all,
    output logic             key_err,
    output logic [CNT_W-1:0] digit_count
);

    localparam int               TO_W      = at_least_one($clog2(TIMEOUT_CYCLES + 1));
    localparam bit               TO_EN     = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_DIGITS);
    localparam logic [TO_W-1:0]  TO_RELOAD = TO_W'(TIMEOUT_CYCLES);

    logic key_event;
    key_t key;

    wr_state_t        state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [TO_W-1:0]  to_d, to_q;
    logic [DIG_W-1:0] dig_idx_d, dig_idx_q;
    logic             operand_sel_d, operand_sel_q;
    logic             store_dig_d, store_dig_q;
    logic             del_dig_d, del_dig_q;
    logic             reg_num_d, reg_num_q;
    logic             result_ready_d, result_ready_q;
    logic             clear_all_d, clear_all_q;
    logic             key_err_d, key_err_q;
    logic             to_running;

    strobe_edge_det #(
        .RESET_VAL (1'b1)
    ) u_strobe_edge_det (
        .clk    (clk),
        .rst    (rst),
        .strobe (key_strobe),
        .rise   (key_event)
    );

    assign key = encode_key(isclr, isbksp, isreg, isop, isdig);

    // An empty operand A is the idle condition: nothing to time out.
    assign to_running = !(state_q == ENTER_A && cnt_q == '0);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        to_d           = to_q;
        dig_idx_d      = dig_idx_q;
        store_dig_d    = 1'b0;
        del_dig_d      = 1'b0;
        reg_num_d      = 1'b0;
        result_ready_d = 1'b0;
        clear_all_d    = 1'b0;
        key_err_d      = 1'b0;

        if (key_event && key != K_NONE) begin
            // A key in the expiry cycle takes this branch, so the pending
            // timeout is simply dropped in favour of the reload.
            if (TO_EN) begin
                to_d = TO_RELOAD;
            end
            case (key)
                K_CLR: begin
                    clear_all_d = 1'b1;
                    state_d     = ENTER_A;
                    cnt_d       = '0;
                end
                K_BKSP: begin
                    if (cnt_q != '0) begin
                        cnt_d     = cnt_q - CNT_W'(1);
                        dig_idx_d = DIG_W'(cnt_q - CNT_W'(1));
                        del_dig_d = 1'b1;
                    end else begin
                        key_err_d = 1'b1;
                    end
                end
                K_REG: begin
                    if (state_q == ENTER_A && cnt_q != '0) begin
                        reg_num_d = 1'b1;
                        state_d   = ENTER_B;
                        cnt_d     = '0;
                    end else begin
                        key_err_d = 1'b1;
                    end
                end
                K_OP: begin
                    if (state_q == ENTER_B && cnt_q != '0) begin
                        result_ready_d = 1'b1;
                        state_d        = ENTER_A;
                        cnt_d          = '0;
                    end else begin
                        key_err_d = 1'b1;
                    end
                end
                K_DIG: begin
                    if (cnt_q < MAX_CNT) begin
                        store_dig_d = 1'b1;
                        dig_idx_d   = DIG_W'(cnt_q);
                        cnt_d       = cnt_q + CNT_W'(1);
                    end else begin
                        key_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (TO_EN && to_running) begin
            // Reload value N gives expiry on the Nth edge after the key edge.
            if (to_q == TO_W'(1)) begin
                to_d        = '0;
                clear_all_d = 1'b1;
                state_d     = ENTER_A;
                cnt_d       = '0;
            end else if (to_q != '0) begin
                to_d = to_q - TO_W'(1);
            end
        end

        operand_sel_d = (state_d == ENTER_B);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ENTER_A;
            cnt_q          <= '0;
            to_q           <= '0;
            dig_idx_q      <= '0;
            operand_sel_q  <= 1'b0;
            store_dig_q    <= 1'b0;
            del_dig_q      <= 1'b0;
            reg_num_q      <= 1'b0;
            result_ready_q <= 1'b0;
            clear_all_q    <= 1'b0;
            key_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            to_q           <= to_d;
            dig_idx_q      <= dig_idx_d;
            operand_sel_q  <= operand_sel_d;
            store_dig_q    <= store_dig_d;
            del_dig_q      <= del_dig_d;
            reg_num_q      <= reg_num_d;
            result_ready_q <= result_ready_d;
            clear_all_q    <= clear_all_d;
            key_err_q      <= key_err_d;
        end
    end

    assign store_dig    = store_dig_q;
    assign del_dig      = del_dig_q;
    assign dig_idx      = dig_idx_q;
    assign operand_sel  = operand_sel_q;
    assign reg_num      = reg_num_q;
    assign result_ready = result_ready_q;
    assign clear_all    = clear_all_q;
    assign key_err      = key_err_q;
    assign digit_count  = cnt_q;

endmodule
